// File: rtl/sda_kernel_control_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sda_kernel_control_regs
// Brief    : AXI4-Lite control/parameter register file for the kernel action.
//            Sequences the go/done handshake, serves the parameter-read
//            channel and raises a level interrupt on completion.
// Revision : 1.0 - initial release
// ============================================================================
module sda_kernel_control_regs #(
  parameter int NUM_PARAMS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  input  logic        param_addr_0r,
  input  logic [31:0] param_addr,
  output logic        param_addr_0a,
  output logic        param_data_0r,
  output logic [31:0] param_data,
  input  logic        param_data_0a,
  output logic        interrupt
);

  // Decoded address: 8 bits of control space plus the parameter index bits.
  localparam int c_IW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int c_AW = 8 + c_IW;
  localparam int c_WW = c_AW - 2;
  localparam logic [c_WW-1:0] c_CTRL = c_WW'(0);
  localparam logic [c_WW-1:0] c_GIE  = c_WW'(1);
  localparam logic [c_WW-1:0] c_IER  = c_WW'(2);
  localparam logic [c_WW-1:0] c_ISR  = c_WW'(3);

  typedef enum logic [1:0] {S_IDLE, S_GO_REQ, S_RUN, S_DONE_ACK} t_act_state;
  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DROP} t_par_state;

  t_act_state r_act_state, w_act_next;
  t_par_state r_par_state, w_par_next;

  logic        r_wr_ready, r_bvalid, r_arready, r_rvalid;
  logic [31:0] r_rdata, w_rd_data, r_pdata, w_pval;
  logic        r_gie, r_ier, r_isr, r_ap_done, r_start_pend, r_paddr_ack;
  logic [31:0] r_param [NUM_PARAMS];

  logic [c_WW-1:0] w_wr_idx, w_rd_idx;
  logic            w_wr_en, w_start, w_complete, w_busy, w_unused;

  assign w_wr_idx   = s_axi_awaddr[c_AW-1:2];
  assign w_rd_idx   = s_axi_araddr[c_AW-1:2];
  assign w_wr_en    = r_wr_ready;
  assign w_start    = w_wr_en && (w_wr_idx == c_CTRL) && s_axi_wstrb[0] &&
                      s_axi_wdata[0] && (r_act_state == S_IDLE);
  assign w_complete = (r_act_state == S_DONE_ACK) && !done_0r;
  assign w_busy     = (r_act_state != S_IDLE) || r_start_pend;
  assign w_unused   = ^{s_axi_araddr[31:c_AW], s_axi_araddr[1:0],
                        s_axi_awaddr[31:c_AW], s_axi_awaddr[1:0],
                        s_axi_arcache, s_axi_arprot, s_axi_awcache, s_axi_awprot};

  assign s_axi_awready = r_wr_ready;
  assign s_axi_wready  = r_wr_ready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign go_0r         = (r_act_state == S_GO_REQ);
  assign done_0a       = (r_act_state == S_DONE_ACK);
  assign param_addr_0a = r_paddr_ack;
  assign param_data_0r = (r_par_state == P_ADDR);
  assign param_data    = r_pdata;
  assign interrupt     = r_gie & r_ier & r_isr;

  // Write channel: one-cycle accept of a paired AW/W, response held until bready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ready <= 1'b0;
      r_bvalid   <= 1'b0;
    end else begin
      r_wr_ready <= s_axi_awvalid && s_axi_wvalid && !r_wr_ready && !r_bvalid;
      if (r_wr_ready)        r_bvalid <= 1'b1;
      else if (s_axi_bready) r_bvalid <= 1'b0;
    end
  end

  // Read data mux for the address presented during the arready cycle.
  always_comb begin
    w_rd_data = 32'h0;
    case (w_rd_idx)
      c_CTRL:  w_rd_data = {29'h0, !w_busy, r_ap_done, w_busy};
      c_GIE:   w_rd_data = {31'h0, r_gie};
      c_IER:   w_rd_data = {31'h0, r_ier};
      c_ISR:   w_rd_data = {31'h0, r_isr};
      default: begin
        for (int i = 0; i < NUM_PARAMS; i++)
          if (w_rd_idx == c_WW'(i + 4)) w_rd_data = r_param[i];
      end
    endcase
  end

  // Read channel: accept one cycle after arvalid, data held until rready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_arready <= s_axi_arvalid && !r_arready && !r_rvalid;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Host-visible control and parameter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gie        <= 1'b0;
      r_ier        <= 1'b0;
      r_isr        <= 1'b0;
      r_ap_done    <= 1'b0;
      r_start_pend <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) r_param[i] <= 32'h0;
    end else begin
      if (w_wr_en && (w_wr_idx == c_GIE) && s_axi_wstrb[0]) r_gie <= s_axi_wdata[0];
      if (w_wr_en && (w_wr_idx == c_IER) && s_axi_wstrb[0]) r_ier <= s_axi_wdata[0];
      // Completion takes priority over a simultaneous host toggle / clear-on-read.
      if (w_complete) r_isr <= 1'b1;
      else if (w_wr_en && (w_wr_idx == c_ISR) && s_axi_wstrb[0] && s_axi_wdata[0])
        r_isr <= ~r_isr;
      if (w_complete) r_ap_done <= 1'b1;
      else if (r_arready && (w_rd_idx == c_CTRL)) r_ap_done <= 1'b0;
      // A start written while go_0a is still high waits here for its return to zero.
      if (r_act_state != S_IDLE) r_start_pend <= 1'b0;
      else if (w_start)          r_start_pend <= 1'b1;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (w_wr_en && (w_wr_idx == c_WW'(i + 4))) begin
          for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b]) r_param[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Action FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_act_state <= S_IDLE;
    else       r_act_state <= w_act_next;
  end

  // Action FSM next state: go request, run, done acknowledge.
  always_comb begin
    w_act_next = r_act_state;
    case (r_act_state)
      S_IDLE:     if ((w_start || r_start_pend) && !go_0a) w_act_next = S_GO_REQ;
      S_GO_REQ:   if (go_0a)    w_act_next = S_RUN;
      S_RUN:      if (done_0r)  w_act_next = S_DONE_ACK;
      S_DONE_ACK: if (!done_0r) w_act_next = S_IDLE;
      default:    w_act_next = S_IDLE;
    endcase
  end

  // Parameter value selected by the requested word index (zero when out of range).
  always_comb begin
    w_pval = 32'h0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (param_addr == 32'(i)) w_pval = r_param[i];
  end

  // Param FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_par_state <= P_IDLE;
    else       r_par_state <= w_par_next;
  end

  // Param FSM next state: latch, hold data until acknowledged, wait for release.
  always_comb begin
    w_par_next = r_par_state;
    case (r_par_state)
      P_IDLE:  if (param_addr_0r) w_par_next = P_ADDR;
      P_ADDR:  if (param_data_0a) w_par_next = P_DROP;
      P_DROP:  if (!param_data_0a && !r_paddr_ack) w_par_next = P_IDLE;
      default: w_par_next = P_IDLE;
    endcase
  end

  // Address acknowledge and snapshot of the parameter value at latch time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paddr_ack <= 1'b0;
      r_pdata     <= 32'h0;
    end else if ((r_par_state == P_IDLE) && param_addr_0r) begin
      r_paddr_ack <= 1'b1;
      r_pdata     <= w_pval;
    end else if (!param_addr_0r) begin
      r_paddr_ack <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sda_kernel_control_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sda_kernel_control_regs
// Brief    : Self-checking bench for sda_kernel_control_regs with a register
//            map reference model and a behavioural action stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sda_kernel_control_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axi_araddr = 0, s_axi_awaddr = 0, s_axi_wdata = 0;
  logic        s_axi_arvalid = 0, s_axi_rready = 0, s_axi_awvalid = 0;
  logic        s_axi_wvalid = 0, s_axi_bready = 0;
  logic [3:0]  s_axi_wstrb = 0;
  logic        s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_bvalid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  logic        go_0r, go_0a, done_0r, done_0a;
  logic        param_addr_0r = 0, param_data_0a = 0;
  logic [31:0] param_addr = 0, param_data;
  logic        param_addr_0a, param_data_0r, interrupt;

  always #5 clk = ~clk;

  sda_kernel_control_regs #(.NUM_PARAMS(16)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arcache(4'h3), .s_axi_arprot(3'h0), .s_axi_awcache(4'h3), .s_axi_awprot(3'h0),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_addr_0r(param_addr_0r), .param_addr(param_addr), .param_addr_0a(param_addr_0a),
    .param_data_0r(param_data_0r), .param_data(param_data), .param_data_0a(param_data_0a),
    .interrupt(interrupt)
  );

  // Action stub: acknowledges go, reports done (when released), drops on done_0a.
  logic stub_en = 0, release_done = 1, ack;
  assign go_0a   = ack;
  assign done_0r = ack & release_done;
  always @(posedge clk or posedge reset) begin
    if (reset)        ack <= 1'b0;
    else if (stub_en) begin
      if (go_0r)        ack <= 1'b1;
      else if (done_0a) ack <= 1'b0;
    end
  end

  // Count go pulses and completion acknowledges seen by the action.
  int   go_cnt = 0, done_cnt = 0;
  logic go_prev = 0, dn_prev = 0;
  always @(posedge clk) begin
    go_prev <= go_0r;
    dn_prev <= done_0a;
    if (go_0r && !go_prev)   go_cnt   <= go_cnt + 1;
    if (done_0a && !dn_prev) done_cnt <= done_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model of the host-visible register map (action assumed idle).
  logic [31:0] m_param [16];
  logic        m_gie, m_ier, m_isr, m_done;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_param[i] = 0;
    m_gie = 0; m_ier = 0; m_isr = 0; m_done = 0;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    if (a == 32'h4 && s[0]) m_gie = d[0];
    if (a == 32'h8 && s[0]) m_ier = d[0];
    if (a == 32'hC && s[0] && d[0]) m_isr = ~m_isr;
    if (a >= 32'h10 && a < 32'h50) begin
      k = int'((a - 32'h10) >> 2);
      for (int b = 0; b < 4; b++) if (s[b]) m_param[k][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == 32'h0) return {29'h0, 1'b1, m_done, 1'b0};
    if (a == 32'h4) return {31'h0, m_gie};
    if (a == 32'h8) return {31'h0, m_ier};
    if (a == 32'hC) return {31'h0, m_isr};
    if (a >= 32'h10 && a < 32'h50) return m_param[int'((a - 32'h10) >> 2)];
    return 32'h0;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bwait);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge clk); #1;
    chk("wr_ready", {30'h0, s_axi_awready, s_axi_wready}, 32'h3);
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("wr_ready_single", {30'h0, s_axi_awready, s_axi_wready}, 32'h0);
    chk("bvalid", {30'h0, s_axi_bresp}, 32'h0);
    chk("bvalid_up", s_axi_bvalid, 1);
    for (int i = 0; i < bwait; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", s_axi_bvalid, 1);
    end
    s_axi_bready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0;
    chk("bvalid_drop", s_axi_bvalid, 0);
    m_write(a, d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rwait, output logic [31:0] data);
    s_axi_araddr = a; s_axi_arvalid = 1;
    @(posedge clk); #1;
    chk("arready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    chk("arready_single", s_axi_arready, 0);
    chk("rvalid_up", s_axi_rvalid, 1);
    chk("rresp", {30'h0, s_axi_rresp}, 32'h0);
    data = s_axi_rdata;
    for (int i = 0; i < rwait; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", s_axi_rvalid, 1);
      chk("rdata_hold", s_axi_rdata, data);
    end
    s_axi_rready = 1;
    @(posedge clk); #1;
    s_axi_rready = 0;
    chk("rvalid_drop", s_axi_rvalid, 0);
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input int rwait);
    logic [31:0] exp, got;
    exp = m_read(a);
    axi_read(a, rwait, got);
    chk(tag, got, exp);
    if (a == 32'h0) m_done = 0;
  endtask

  // Full parameter-channel handshake; optionally a host write lands mid-flight.
  task automatic param_req(input logic [31:0] idx, input int hold, input logic [31:0] exp,
                           input bit host_wr);
    param_addr = idx; param_addr_0r = 1;
    @(posedge clk); #1;
    chk("p_addr_0a", param_addr_0a, 1);
    chk("p_data_0r", param_data_0r, 1);
    chk("p_data", param_data, exp);
    param_addr_0r = 0; param_addr = $urandom;
    @(posedge clk); #1;
    chk("p_addr_0a_drop", param_addr_0a, 0);
    if (host_wr) axi_write(32'h10 + 4 * idx, ~exp, 4'hF, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("p_data_hold", param_data, exp);
      chk("p_data_0r_hold", param_data_0r, 1);
    end
    param_data_0a = 1;
    @(posedge clk); #1;
    chk("p_data_0r_drop", param_data_0r, 0);
    param_data_0a = 0;
    @(posedge clk); #1;
  endtask

  // Waits for the running action to complete and updates the model.
  task automatic wait_completion();
    for (int i = 0; i < 40 && !done_0a; i++) begin @(posedge clk); #1; end
    chk("done_0a_seen", done_0a, 1);
    for (int i = 0; i < 40 && done_0a; i++) begin @(posedge clk); #1; end
    chk("done_0a_drop", done_0a, 0);
    m_done = 1; m_isr = 1;
    chk("irq_after_done", interrupt, m_gie & m_ier & m_isr);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_axi"}, {27'h0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                        s_axi_arready, s_axi_rvalid}, 32'h0);
    chk({tag, "_rdata"}, s_axi_rdata, 32'h0);
    chk({tag, "_hs"}, {27'h0, go_0r, done_0a, param_addr_0a, param_data_0r, interrupt}, 32'h0);
    chk({tag, "_pdata"}, param_data, 32'h0);
  endtask

  int g0, d0;
  logic [31:0] a, d, rd;

  initial begin
    m_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 0;
    @(posedge clk); #1;

    // Parameter writes with byte strobes, responses held by withheld ready.
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 3);
    axi_write(32'h14, 32'h12345678, 4'b0011, 0);
    check_read("param0", 32'h10, 3);
    check_read("param1_strb", 32'h14, 0);
    check_read("ctrl_reset", 32'h0, 0);
    check_read("unmapped", 32'h50, 0);

    // First action run: go held until acknowledged, then one done cycle.
    axi_write(32'h4, 1, 4'hF, 0);
    axi_write(32'h8, 1, 4'hF, 0);
    g0 = go_cnt; d0 = done_cnt;
    release_done = 1; stub_en = 0;
    axi_write(32'h0, 1, 4'hF, 0);
    chk("go_0r_held", go_0r, 1);
    axi_read(32'h0, 0, rd);
    chk("ctrl_busy", rd, 32'h1);
    stub_en = 1;
    for (int i = 0; i < 10 && !go_0a; i++) begin @(posedge clk); #1; end
    chk("go_0a_seen", go_0a, 1);
    chk("go_0r_before_ack", go_0r, 1);
    @(posedge clk); #1;
    chk("go_0r_after_ack", go_0r, 0);
    wait_completion();
    chk("irq_set", interrupt, 1);
    check_read("ctrl_done", 32'h0, 0);
    check_read("ctrl_done_cleared", 32'h0, 0);
    axi_write(32'hC, 1, 4'hF, 0);
    chk("irq_cleared", interrupt, 0);
    chk("go_count_run1", go_cnt - g0, 1);
    chk("done_count_run1", done_cnt - d0, 1);

    // Start written during RUN is ignored.
    g0 = go_cnt; d0 = done_cnt;
    release_done = 0;
    axi_write(32'h0, 1, 4'hF, 0);
    for (int i = 0; i < 20 && !(go_0a && !go_0r); i++) begin @(posedge clk); #1; end
    chk("in_run", {31'h0, go_0a && !go_0r}, 32'h1);
    axi_write(32'h0, 1, 4'hF, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_second_go", go_cnt - g0, 1);
    axi_read(32'h0, 0, rd);
    chk("ctrl_run", rd, 32'h1);
    release_done = 1;
    wait_completion();
    repeat (5) @(posedge clk);
    #1;
    chk("single_go", go_cnt - g0, 1);
    chk("single_done", done_cnt - d0, 1);
    chk("idle_after_run", {30'h0, go_0r, done_0a}, 32'h0);
    check_read("ctrl_done2", 32'h0, 0);

    // Parameter channel: held data, snapshot against host writes, out of range.
    axi_write(32'h14, 32'hCAFE0001, 4'hF, 0);
    param_req(1, 10, 32'hCAFE0001, 1'b1);
    check_read("param1_after_snapshot", 32'h14, 0);
    param_req(300, 2, 32'h0, 1'b0);

    // Concurrent read and write on different registers.
    d = m_read(32'h1C);
    fork
      axi_write(32'h18, 32'hA5A5_5A5A, 4'hF, 1);
      axi_read(32'h1C, 1, rd);
    join
    chk("concurrent_read", rd, d);
    check_read("concurrent_write", 32'h18, 0);

    // Randomised traffic against the register model.
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(1, 63)) * 4;
      d = $urandom;
      axi_write(a, d, 4'($urandom), $urandom_range(0, 2));
      chk("rand_irq", interrupt, m_gie & m_ier & m_isr);
      a = 32'($urandom_range(0, 63)) * 4;
      check_read("rand_read", a, $urandom_range(0, 2));
      d = 32'($urandom_range(0, 19));
      param_req(d, $urandom_range(0, 3), (d < 16) ? m_param[int'(d)] : 32'h0, 1'b0);
    end

    // Asynchronous reset while in GO_REQ and P_ADDR.
    axi_write(32'h4, 1, 4'h1, 0);
    axi_write(32'h8, 1, 4'h1, 0);
    if (!m_isr) axi_write(32'hC, 1, 4'h1, 0);
    stub_en = 0;
    axi_write(32'h0, 1, 4'hF, 0);
    param_addr = 2; param_addr_0r = 1;
    @(posedge clk); #1;
    chk("pre_reset_go", go_0r, 1);
    chk("pre_reset_paddr", param_addr_0a, 1);
    chk("pre_reset_irq", interrupt, 1);
    #2 reset = 1;
    #1;
    check_outputs_zero("async_reset");
    param_addr_0r = 0;
    @(posedge clk); #1;
    reset = 0;
    m_reset();
    stub_en = 1;
    @(posedge clk); #1;
    check_read("post_reset_param", 32'h14, 0);
    check_read("post_reset_ctrl", 32'h0, 0);
    g0 = go_cnt;
    axi_write(32'h0, 1, 4'hF, 0);
    wait_completion();
    chk("post_reset_go", go_cnt - g0, 1);
    chk("post_reset_irq_masked", interrupt, 0);
    check_read("post_reset_done", 32'h0, 0);
    param_req(3, 1, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
